// File: rtl/imem_dmem_arbiter_if.sv
// Bundle of the fetch, load/store and shared-memory handshake signals seen by the arbiter.
// The slave modport is the arbiter's view; master is the requesters' and the memory's side.
interface imem_dmem_arbiter_if;
  logic        if_valid_i;
  logic [31:0] if_addr_i;
  logic        if_ready_o;
  logic        if_rvalid_ro;
  logic [31:0] if_rdata_ro;
  logic        if_rready_i;
  logic        flush_i;

  logic        ls_valid_i;
  logic [31:0] ls_addr_i;
  logic        ls_we_i;
  logic [3:0]  ls_wstrb_i;
  logic [31:0] ls_wdata_i;
  logic        ls_ready_o;
  logic        ls_rvalid_ro;
  logic [31:0] ls_rdata_ro;
  logic        ls_rready_i;

  logic        mem_req_ro;
  logic [31:0] mem_addr_ro;
  logic [31:0] mem_wdata_ro;
  logic        mem_we_ro;
  logic [3:0]  mem_wstrb_ro;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  if_valid_i, if_addr_i, if_rready_i, flush_i,
    input  ls_valid_i, ls_addr_i, ls_we_i, ls_wstrb_i, ls_wdata_i, ls_rready_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_ready_o, if_rvalid_ro, if_rdata_ro,
    output ls_ready_o, ls_rvalid_ro, ls_rdata_ro,
    output mem_req_ro, mem_addr_ro, mem_wdata_ro, mem_we_ro, mem_wstrb_ro
  );

  modport master (
    output if_valid_i, if_addr_i, if_rready_i, flush_i,
    output ls_valid_i, ls_addr_i, ls_we_i, ls_wstrb_i, ls_wdata_i, ls_rready_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_ready_o, if_rvalid_ro, if_rdata_ro,
    input  ls_ready_o, ls_rvalid_ro, ls_rdata_ro,
    input  mem_req_ro, mem_addr_ro, mem_wdata_ro, mem_we_ro, mem_wstrb_ro
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Single-port memory arbiter: one transaction at a time from fetch or LSU, LSU preferred,
// with a starvation counter that forces fetch through and flush-based kill of fetch responses.
module imem_dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  imem_dmem_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic OWN_LS = 1'b0;
  localparam logic OWN_IF = 1'b1;

  localparam logic [3:0] W_LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]  r_state;
  logic        r_owner;
  logic        r_kill;
  logic [3:0]  r_starve;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic        r_if_rvalid;
  logic [31:0] r_if_rdata;
  logic        r_ls_rvalid;
  logic [31:0] r_ls_rdata;

  logic w_idle;
  logic w_if_win;
  logic w_ls_win;
  logic w_own_flush;
  logic w_discard;

  // Fetch is blocked outright during flush; otherwise it only beats a valid LSU once starved.
  assign w_idle      = (r_state == S_IDLE);
  assign w_if_win    = w_idle && bus.if_valid_i && !bus.flush_i &&
                       (!bus.ls_valid_i || (r_starve == W_LIMIT));
  assign w_ls_win    = w_idle && bus.ls_valid_i && !w_if_win;
  assign w_own_flush = (r_owner == OWN_IF) && bus.flush_i;
  assign w_discard   = (r_owner == OWN_IF) && (r_kill || bus.flush_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_LS;
      r_kill      <= 1'b0;
      r_starve    <= 4'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= 32'd0;
      r_ls_rvalid <= 1'b0;
      r_ls_rdata  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_if_win) begin
            r_owner     <= OWN_IF;
            r_kill      <= 1'b0;
            r_starve    <= 4'd0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.if_addr_i;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'd0;
            r_state     <= S_REQ;
          end else if (w_ls_win) begin
            r_owner     <= OWN_LS;
            r_kill      <= 1'b0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.ls_we_i;
            r_mem_addr  <= bus.ls_addr_i;
            r_mem_wdata <= bus.ls_wdata_i;
            r_mem_wstrb <= bus.ls_we_i ? bus.ls_wstrb_i : 4'd0;
            r_state     <= S_REQ;
            if (bus.if_valid_i && (r_starve != W_LIMIT)) begin
              r_starve <= r_starve + 4'd1;
            end
          end
        end
        S_REQ: begin
          // The request is never withdrawn; a flush only marks the answer for disposal.
          if (w_own_flush) begin
            r_kill <= 1'b1;
          end
          if (bus.mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid_i) begin
            if (w_discard) begin
              r_kill  <= 1'b0;
              r_state <= S_IDLE;
            end else if (r_owner == OWN_IF) begin
              r_if_rdata  <= bus.mem_rdata_i;
              r_if_rvalid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_ls_rdata  <= bus.mem_rdata_i;
              r_ls_rvalid <= 1'b1;
              r_state     <= S_RESP;
            end
          end else if (w_own_flush) begin
            r_kill <= 1'b1;
          end
        end
        S_RESP: begin
          if (r_owner == OWN_IF) begin
            if (bus.flush_i || bus.if_rready_i) begin
              r_if_rvalid <= 1'b0;
              r_state     <= S_IDLE;
            end
          end else if (bus.ls_rready_i) begin
            r_ls_rvalid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.if_ready_o   = w_if_win;
  assign bus.ls_ready_o   = w_ls_win;
  assign bus.mem_req_ro   = r_mem_req;
  assign bus.mem_we_ro    = r_mem_we;
  assign bus.mem_addr_ro  = r_mem_addr;
  assign bus.mem_wdata_ro = r_mem_wdata;
  assign bus.mem_wstrb_ro = r_mem_wstrb;
  assign bus.if_rvalid_ro = r_if_rvalid;
  assign bus.if_rdata_ro  = r_if_rdata;
  assign bus.ls_rvalid_ro = r_ls_rvalid;
  assign bus.ls_rdata_ro  = r_ls_rdata;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed vector tables, hand-built corner sequences and a
// randomized run, all compared each cycle against a transaction-level reference model.
module tb_imem_dmem_arbiter;

  localparam int LIMIT = 2;

  typedef struct {
    logic        ifv;
    logic [31:0] ifa;
    logic        flush;
    logic        lsv;
    logic [31:0] lsa;
    logic        lswe;
    logic [3:0]  lsstrb;
    logic [31:0] lswd;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        ifrr;
    logic        lsrr;
  } in_t;

  // e = {if_ready, ls_ready, mem_req, mem_we, if_rvalid, ls_rvalid}; rd checked when a rvalid is expected
  typedef struct {
    in_t         in;
    logic [5:0]  e;
    logic [31:0] rd;
  } vec_t;

  logic clk;
  logic rst;
  imem_dmem_arbiter_if bus ();

  imem_dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the single outstanding transaction and what has happened to it so far.
  bit          m_active, m_granted, m_resp, m_own_if, m_killed;
  int          m_starve;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_ls_rdata;
  logic        m_we;
  logic [3:0]  m_wstrb;

  bit          last_if_rdy, last_ls_rdy;
  bit          grants[$];

  task automatic check1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic in_t nop();
    in_t v;
    v.ifv = 0; v.ifa = 0; v.flush = 0; v.lsv = 0; v.lsa = 0; v.lswe = 0;
    v.lsstrb = 0; v.lswd = 0; v.gnt = 0; v.rv = 0; v.rd = 0; v.ifrr = 0; v.lsrr = 0;
    return v;
  endfunction

  function automatic in_t mk(input logic ifv, input logic [31:0] ifa, input logic lsv,
                             input logic [31:0] lsa, input logic lswe, input logic [3:0] strb,
                             input logic [31:0] wd, input logic gnt, input logic rv,
                             input logic [31:0] rd, input logic ifrr, input logic lsrr);
    in_t v;
    v = nop();
    v.ifv = ifv; v.ifa = ifa; v.lsv = lsv; v.lsa = lsa; v.lswe = lswe; v.lsstrb = strb;
    v.lswd = wd; v.gnt = gnt; v.rv = rv; v.rd = rd; v.ifrr = ifrr; v.lsrr = lsrr;
    return v;
  endfunction

  function automatic vec_t V(input in_t in, input logic [5:0] e, input logic [31:0] rd);
    vec_t t;
    t.in = in; t.e = e; t.rd = rd;
    return t;
  endfunction

  task automatic model_reset();
    m_active = 0; m_granted = 0; m_resp = 0; m_own_if = 0; m_killed = 0; m_starve = 0;
    m_addr = 0; m_wdata = 0; m_we = 0; m_wstrb = 0; m_if_rdata = 0; m_ls_rdata = 0;
  endtask

  function automatic bit model_waiting();
    return m_active && m_granted && !m_resp;
  endfunction

  task automatic model_ready(input in_t v, output bit ifr, output bit lsr);
    bit free_slot;
    free_slot = !m_active;
    ifr = free_slot && v.ifv && !v.flush && (!v.lsv || m_starve == LIMIT);
    lsr = free_slot && v.lsv && !ifr;
  endtask

  task automatic model_clock(input in_t v);
    bit ifr, lsr;
    model_ready(v, ifr, lsr);
    if (!m_active) begin
      if (ifr || lsr) begin
        m_active = 1; m_granted = 0; m_resp = 0; m_killed = 0; m_own_if = ifr;
      end
      if (ifr) begin
        m_addr = v.ifa; m_we = 0; m_wstrb = 0; m_starve = 0;
      end else if (lsr) begin
        m_addr = v.lsa; m_we = v.lswe; m_wstrb = v.lswe ? v.lsstrb : 4'd0; m_wdata = v.lswd;
        if (v.ifv && m_starve < LIMIT) m_starve++;
      end
    end else if (!m_granted) begin
      if (m_own_if && v.flush) m_killed = 1;
      if (v.gnt) m_granted = 1;
    end else if (!m_resp) begin
      if (m_own_if && v.flush) m_killed = 1;
      if (v.rv) begin
        if (m_own_if && m_killed) m_active = 0;
        else begin
          m_resp = 1;
          if (m_own_if) m_if_rdata = v.rd;
          else m_ls_rdata = v.rd;
        end
      end
    end else begin
      if (m_own_if ? (v.flush || v.ifrr) : v.lsrr) m_active = 0;
    end
  endtask

  task automatic drive(input in_t v);
    bus.if_valid_i   = v.ifv;
    bus.if_addr_i    = v.ifa;
    bus.flush_i      = v.flush;
    bus.ls_valid_i   = v.lsv;
    bus.ls_addr_i    = v.lsa;
    bus.ls_we_i      = v.lswe;
    bus.ls_wstrb_i   = v.lsstrb;
    bus.ls_wdata_i   = v.lswd;
    bus.mem_gnt_i    = v.gnt;
    bus.mem_rvalid_i = v.rv;
    bus.mem_rdata_i  = v.rd;
    bus.if_rready_i  = v.ifrr;
    bus.ls_rready_i  = v.lsrr;
  endtask

  // One clock: drive, check the combinational readies, clock, then check registered outputs.
  task automatic step(input in_t v);
    bit e_ifr, e_lsr, e_req;
    drive(v);
    #1;
    model_ready(v, e_ifr, e_lsr);
    check1("if_ready_o", bus.if_ready_o, e_ifr);
    check1("ls_ready_o", bus.ls_ready_o, e_lsr);
    check1("ready_exclusive", bus.if_ready_o && bus.ls_ready_o, 1'b0);
    last_if_rdy = bus.if_ready_o;
    last_ls_rdy = bus.ls_ready_o;
    if (bus.if_ready_o) grants.push_back(1'b1);
    else if (bus.ls_ready_o) grants.push_back(1'b0);
    @(posedge clk);
    model_clock(v);
    #1;
    e_req = m_active && !m_granted;
    check1("mem_req_ro", bus.mem_req_ro, e_req);
    if (e_req) begin
      check32("mem_addr_ro", bus.mem_addr_ro, m_addr);
      check1("mem_we_ro", bus.mem_we_ro, m_we);
      check32("mem_wstrb_ro", {28'd0, bus.mem_wstrb_ro}, {28'd0, m_wstrb});
      if (m_we) check32("mem_wdata_ro", bus.mem_wdata_ro, m_wdata);
    end
    check1("if_rvalid_ro", bus.if_rvalid_ro, m_active && m_resp && m_own_if);
    check1("ls_rvalid_ro", bus.ls_rvalid_ro, m_active && m_resp && !m_own_if);
    check32("if_rdata_ro", bus.if_rdata_ro, m_if_rdata);
    check32("ls_rdata_ro", bus.ls_rdata_ro, m_ls_rdata);
  endtask

  vec_t tbl[18];
  bit   exp_order[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t v;
    logic [31:0] held;

    // Fetch-only 0x100 then 0x104; then simultaneous fetch 0x0 / LSU store 0x2000.
    tbl[0]  = V(mk(1,'h100,0,0,0,0,0,0,0,0,0,0),                 6'b101000, 0);
    tbl[1]  = V(mk(0,0,0,0,0,0,0,1,0,0,0,0),                     6'b000000, 0);
    tbl[2]  = V(mk(0,0,0,0,0,0,0,0,1,'hDEADBEEF,0,0),            6'b000010, 'hDEADBEEF);
    tbl[3]  = V(mk(0,0,0,0,0,0,0,0,0,0,0,0),                     6'b000010, 'hDEADBEEF);
    tbl[4]  = V(mk(0,0,0,0,0,0,0,0,0,0,0,0),                     6'b000010, 'hDEADBEEF);
    tbl[5]  = V(mk(0,0,0,0,0,0,0,0,0,0,1,0),                     6'b000000, 0);
    tbl[6]  = V(mk(1,'h104,0,0,0,0,0,0,0,0,0,0),                 6'b101000, 0);
    tbl[7]  = V(mk(0,0,0,0,0,0,0,1,0,0,0,0),                     6'b000000, 0);
    tbl[8]  = V(mk(0,0,0,0,0,0,0,0,1,'h0BADC0DE,0,0),            6'b000010, 'h0BADC0DE);
    tbl[9]  = V(mk(0,0,0,0,0,0,0,0,0,0,1,0),                     6'b000000, 0);
    tbl[10] = V(mk(1,'h0,1,'h2000,1,'hF,'h12345678,0,0,0,0,0),   6'b011100, 0);
    tbl[11] = V(mk(1,'h0,0,0,0,0,0,1,0,0,0,0),                   6'b000000, 0);
    tbl[12] = V(mk(1,'h0,0,0,0,0,0,0,1,'hA5A5A5A5,0,0),          6'b000001, 'hA5A5A5A5);
    tbl[13] = V(mk(1,'h0,0,0,0,0,0,0,0,0,0,1),                   6'b000000, 0);
    tbl[14] = V(mk(1,'h0,0,0,0,0,0,0,0,0,0,0),                   6'b101000, 0);
    tbl[15] = V(mk(0,0,0,0,0,0,0,1,0,0,0,0),                     6'b000000, 0);
    tbl[16] = V(mk(0,0,0,0,0,0,0,0,1,'h13579BDF,0,0),            6'b000010, 'h13579BDF);
    tbl[17] = V(mk(0,0,0,0,0,0,0,0,0,0,1,0),                     6'b000000, 0);

    rst = 1'b0;
    drive(nop());
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check1("rst_mem_req", bus.mem_req_ro, 1'b0);
    check1("rst_if_rvalid", bus.if_rvalid_ro, 1'b0);
    check1("rst_ls_rvalid", bus.ls_rvalid_ro, 1'b0);
    check32("rst_mem_addr", bus.mem_addr_ro, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].in);
      check1($sformatf("tbl%0d_if_ready", i), last_if_rdy, tbl[i].e[5]);
      check1($sformatf("tbl%0d_ls_ready", i), last_ls_rdy, tbl[i].e[4]);
      check1($sformatf("tbl%0d_mem_req", i), bus.mem_req_ro, tbl[i].e[3]);
      if (tbl[i].e[3]) check1($sformatf("tbl%0d_mem_we", i), bus.mem_we_ro, tbl[i].e[2]);
      check1($sformatf("tbl%0d_if_rvalid", i), bus.if_rvalid_ro, tbl[i].e[1]);
      check1($sformatf("tbl%0d_ls_rvalid", i), bus.ls_rvalid_ro, tbl[i].e[0]);
      if (tbl[i].e[1]) check32($sformatf("tbl%0d_if_rdata", i), bus.if_rdata_ro, tbl[i].rd);
      if (tbl[i].e[0]) check32($sformatf("tbl%0d_ls_rdata", i), bus.ls_rdata_ro, tbl[i].rd);
    end

    // Starvation: both requesters always valid, zero-wait memory.
    grants.delete();
    for (int c = 0; c < 200 && grants.size() < 6; c++) begin
      v = mk(1, 32'h1000 + 32'(c), 1, 32'h3000 + 32'(c), 0, 0, 0, 1, 0, 32'(c), 1, 1);
      v.rv = model_waiting();
      step(v);
    end
    check32("starve_grant_count", 32'(grants.size()), 32'd6);
    for (int k = 0; k < 6 && k < grants.size(); k++)
      check1($sformatf("starve_order%0d", k), grants[k], exp_order[k]);
    for (int c = 0; c < 20 && m_active; c++) begin
      v = nop(); v.gnt = 1; v.rv = model_waiting(); v.ifrr = 1; v.lsrr = 1;
      step(v);
    end

    // Flush while fetch waits for data; following LSU load must be unaffected.
    v = nop(); v.ifv = 1; v.ifa = 32'h40; step(v);
    check1("fw_accept", last_if_rdy, 1'b1);
    v = nop(); v.gnt = 1; step(v);
    v = nop(); v.flush = 1; step(v);
    check1("fw_no_rvalid_a", bus.if_rvalid_ro, 1'b0);
    v = nop(); step(v);
    v = nop(); v.rv = 1; v.rd = 32'hBAD0BAD0; v.lsv = 1; v.lsa = 32'h300; step(v);
    check1("fw_busy_until_rvalid", last_ls_rdy, 1'b0);
    check1("fw_no_rvalid_b", bus.if_rvalid_ro, 1'b0);
    v = nop(); v.lsv = 1; v.lsa = 32'h300; step(v);
    check1("fw_idle_after_rvalid", last_ls_rdy, 1'b1);
    check1("fw_no_rvalid_c", bus.if_rvalid_ro, 1'b0);
    v = nop(); v.gnt = 1; step(v);
    v = nop(); v.rv = 1; v.rd = 32'h000055AA; step(v);
    check1("fw_load_rvalid", bus.ls_rvalid_ro, 1'b1);
    check32("fw_load_rdata", bus.ls_rdata_ro, 32'h000055AA);
    v = nop(); v.lsrr = 1; step(v);

    // Backpressure: late grant, slow consumer, competing requests must wait.
    v = nop(); v.ifv = 1; v.ifa = 32'h800; step(v);
    for (int c = 0; c < 3; c++) begin
      v = nop(); v.lsv = 1; v.lsa = 32'h7777; v.ifa = 32'h999; step(v);
      check32($sformatf("bp_addr_stable%0d", c), bus.mem_addr_ro, 32'h800);
      check1($sformatf("bp_req_held%0d", c), bus.mem_req_ro, 1'b1);
    end
    v = nop(); v.gnt = 1; step(v);
    v = nop(); v.rv = 1; v.rd = 32'h600DF00D; step(v);
    held = bus.if_rdata_ro;
    for (int c = 0; c < 5; c++) begin
      v = nop(); v.ifv = 1; v.lsv = 1; v.rd = 32'hFFFFFFFF; step(v);
      check1($sformatf("bp_no_accept%0d", c), last_if_rdy || last_ls_rdy, 1'b0);
      check32($sformatf("bp_rdata_stable%0d", c), bus.if_rdata_ro, 32'h600DF00D);
    end
    check32("bp_rdata_first", held, 32'h600DF00D);
    v = nop(); v.ifrr = 1; step(v);
    check1("bp_consumed", bus.if_rvalid_ro, 1'b0);

    // Asynchronous reset in WAIT, then a stale rvalid in the first cycle after release.
    v = nop(); v.ifv = 1; v.ifa = 32'h880; step(v);
    v = nop(); v.gnt = 1; step(v);
    #1;
    rst = 1'b0;
    #1;
    check1("areset_mem_req", bus.mem_req_ro, 1'b0);
    check1("areset_mem_we", bus.mem_we_ro, 1'b0);
    check1("areset_if_rvalid", bus.if_rvalid_ro, 1'b0);
    check1("areset_ls_rvalid", bus.ls_rvalid_ro, 1'b0);
    check32("areset_mem_addr", bus.mem_addr_ro, 32'd0);
    check32("areset_mem_wdata", bus.mem_wdata_ro, 32'd0);
    check32("areset_mem_wstrb", {28'd0, bus.mem_wstrb_ro}, 32'd0);
    check32("areset_if_rdata", bus.if_rdata_ro, 32'd0);
    check32("areset_ls_rdata", bus.ls_rdata_ro, 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    v = nop(); v.ifv = 1; v.ifa = 32'h900; v.rv = 1; v.rd = 32'h51A1E000; step(v);
    check1("areset_first_accept", last_if_rdy, 1'b1);
    check1("areset_stale_ignored", bus.if_rvalid_ro, 1'b0);
    v = nop(); v.gnt = 1; step(v);
    v = nop(); v.rv = 1; v.rd = 32'h0000F00D; step(v);
    check32("areset_after_rdata", bus.if_rdata_ro, 32'h0000F00D);
    v = nop(); v.ifrr = 1; step(v);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      v.ifv    = ($urandom % 10) < 7;
      v.ifa    = $urandom;
      v.flush  = ($urandom % 10) == 0;
      v.lsv    = ($urandom % 2) == 1;
      v.lsa    = $urandom;
      v.lswe   = ($urandom % 2) == 1;
      v.lsstrb = 4'($urandom);
      v.lswd   = $urandom;
      v.gnt    = ($urandom % 2) == 1;
      v.rv     = model_waiting() && (($urandom % 2) == 1);
      v.rd     = $urandom;
      v.ifrr   = ($urandom % 2) == 1;
      v.lsrr   = ($urandom % 2) == 1;
      step(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
